// File: rtl/battle_pkg.sv
// ============================================================================
//  Module  : battle_pkg
//  Purpose : Shared types and USB HID keycodes for the tank game controls.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package battle_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COOLDOWN = 2'd2
  } fire_state_t;

  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_P     = 8'h13;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_ESC   = 8'h29;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_UP    = 8'h52;

  // An empty slot reads 0x00, so code 0x00 must never count as held.
  function automatic logic key_held(input logic [15:0] kc, input logic [7:0] code);
    return (code != 8'h00) && ((kc[7:0] == code) || (kc[15:8] == code));
  endfunction

endpackage

`default_nettype wire

// File: rtl/player_ctrl.sv
// ============================================================================
//  Module  : player_ctrl
//  Purpose : Per-player key decode, facing direction and frame-paced fire FSM.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module player_ctrl
  import battle_pkg::*;
#(
  parameter int         FIRE_COOLDOWN = 8,
  parameter bit         AUTO_REPEAT   = 1'b1,
  parameter logic [7:0] KEY_UP        = KC_W,
  parameter logic [7:0] KEY_RIGHT     = KC_D,
  parameter logic [7:0] KEY_DOWN      = KC_S,
  parameter logic [7:0] KEY_LEFT      = KC_A,
  parameter logic [7:0] KEY_FIRE      = KC_SPACE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_kc,
  input  logic        i_frame_tick,
  input  logic        i_paused,
  input  logic        i_paused_next,
  output logic [1:0]  o_dir,
  output logic        o_move,
  output logic        o_fire
);

  localparam logic [7:0] C_COOLDOWN = 8'(FIRE_COOLDOWN);

  // Bit order doubles as priority order: up > right > down > left.
  logic [3:0]  w_held;
  logic [3:0]  w_dir_edge;
  logic [3:0]  r_held_prev;
  logic        w_fire_held;
  logic        w_fire_edge;
  logic        r_fire_prev;
  dir_t        r_dir;
  dir_t        w_dir_next;
  logic        r_move;
  fire_state_t r_state;
  fire_state_t w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        w_fire;

  function automatic dir_t pick_dir(input logic [3:0] keys);
    if (keys[0])      return DIR_UP;
    else if (keys[1]) return DIR_RIGHT;
    else if (keys[2]) return DIR_DOWN;
    else              return DIR_LEFT;
  endfunction

  assign w_held      = {key_held(i_kc, KEY_LEFT), key_held(i_kc, KEY_DOWN),
                        key_held(i_kc, KEY_RIGHT), key_held(i_kc, KEY_UP)};
  assign w_dir_edge  = w_held & ~r_held_prev;
  assign w_fire_held = key_held(i_kc, KEY_FIRE);
  assign w_fire_edge = w_fire_held & ~r_fire_prev;

  always_comb begin
    w_dir_next = r_dir;
    if (|w_dir_edge)
      w_dir_next = pick_dir(w_dir_edge);
    else if ((|w_held) && !w_held[r_dir])
      w_dir_next = pick_dir(w_held);
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fire       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fire_edge)
          w_state_next = ARMED;
      end
      ARMED: begin
        if (i_frame_tick) begin
          w_fire       = 1'b1;
          w_cnt_next   = C_COOLDOWN;
          w_state_next = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (i_frame_tick) begin
          if (r_cnt > 8'd1) begin
            w_cnt_next = r_cnt - 8'd1;
          end else if (AUTO_REPEAT && w_fire_held) begin
            w_fire     = 1'b1;
            w_cnt_next = C_COOLDOWN;
          end else begin
            w_cnt_next   = 8'd0;
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
    // Pause parks the FSM so nothing pressed meanwhile is replayed later.
    if (i_paused) begin
      w_state_next = IDLE;
      w_cnt_next   = 8'd0;
      w_fire       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held_prev <= 4'd0;
      r_fire_prev <= 1'b0;
      r_dir       <= DIR_UP;
      r_move      <= 1'b0;
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
    end else begin
      r_held_prev <= w_held;
      r_fire_prev <= w_fire_held;
      r_dir       <= w_dir_next;
      r_move      <= (|w_held) & ~i_paused_next;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
    end
  end

  // Fire is a one-cycle pulse aligned with the frame tick itself.
  assign o_dir  = r_dir;
  assign o_move = r_move;
  assign o_fire = w_fire;

endmodule

`default_nettype wire

// File: rtl/keycode_ctrl.sv
// ============================================================================
//  Module  : keycode_ctrl
//  Purpose : Keycode PIO word to registered tank controls and pause flag.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module keycode_ctrl
  import battle_pkg::*;
#(
  parameter int FIRE_COOLDOWN = 8,
  parameter bit AUTO_REPEAT   = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] keycode,
  input  logic        frame_tick,
  output logic [1:0]  p1_dir,
  output logic        p1_move,
  output logic        p1_fire,
  output logic [1:0]  p2_dir,
  output logic        p2_move,
  output logic        p2_fire,
  output logic        paused
);

  logic [15:0] r_kc_q;
  logic        r_pause_prev;
  logic        r_paused;
  logic        w_pause_held;
  logic        w_paused_next;

  assign w_pause_held  = key_held(r_kc_q, KC_P) | key_held(r_kc_q, KC_ESC);
  assign w_paused_next = r_paused ^ (w_pause_held & ~r_pause_prev);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_kc_q       <= 16'd0;
      r_pause_prev <= 1'b0;
      r_paused     <= 1'b0;
    end else begin
      r_kc_q       <= keycode;
      r_pause_prev <= w_pause_held;
      r_paused     <= w_paused_next;
    end
  end

  assign paused = r_paused;

  player_ctrl #(
    .FIRE_COOLDOWN (FIRE_COOLDOWN),
    .AUTO_REPEAT   (AUTO_REPEAT),
    .KEY_UP        (KC_W),
    .KEY_RIGHT     (KC_D),
    .KEY_DOWN      (KC_S),
    .KEY_LEFT      (KC_A),
    .KEY_FIRE      (KC_SPACE)
  ) u_p1 (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .i_kc          (r_kc_q),
    .i_frame_tick  (frame_tick),
    .i_paused      (r_paused),
    .i_paused_next (w_paused_next),
    .o_dir         (p1_dir),
    .o_move        (p1_move),
    .o_fire        (p1_fire)
  );

  player_ctrl #(
    .FIRE_COOLDOWN (FIRE_COOLDOWN),
    .AUTO_REPEAT   (AUTO_REPEAT),
    .KEY_UP        (KC_UP),
    .KEY_RIGHT     (KC_RIGHT),
    .KEY_DOWN      (KC_DOWN),
    .KEY_LEFT      (KC_LEFT),
    .KEY_FIRE      (KC_ENTER)
  ) u_p2 (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .i_kc          (r_kc_q),
    .i_frame_tick  (frame_tick),
    .i_paused      (r_paused),
    .i_paused_next (w_paused_next),
    .o_dir         (p2_dir),
    .o_move        (p2_move),
    .o_fire        (p2_fire)
  );

endmodule

`default_nettype wire

// File: tb/tb_keycode_ctrl.sv
// ============================================================================
//  Module  : tb_keycode_ctrl
//  Purpose : Directed self-checking bench for keycode_ctrl (repeat and one-shot).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keycode_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] keycode;
  logic        frame_tick;

  logic [1:0] a_p1_dir, a_p2_dir, b_p1_dir, b_p2_dir;
  logic       a_p1_move, a_p1_fire, a_p2_move, a_p2_fire, a_paused;
  logic       b_p1_move, b_p1_fire, b_p2_move, b_p2_fire, b_paused;

  logic fa1, fa2, fb1;
  int   checks = 0;
  int   errors = 0;

  keycode_ctrl #(.FIRE_COOLDOWN(3), .AUTO_REPEAT(1'b1)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .keycode(keycode), .frame_tick(frame_tick),
    .p1_dir(a_p1_dir), .p1_move(a_p1_move), .p1_fire(a_p1_fire),
    .p2_dir(a_p2_dir), .p2_move(a_p2_move), .p2_fire(a_p2_fire),
    .paused(a_paused)
  );

  keycode_ctrl #(.FIRE_COOLDOWN(3), .AUTO_REPEAT(1'b0)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .keycode(keycode), .frame_tick(frame_tick),
    .p1_dir(b_p1_dir), .p1_move(b_p1_move), .p1_fire(b_p1_fire),
    .p2_dir(b_p2_dir), .p2_move(b_p2_move), .p2_fire(b_p2_fire),
    .paused(b_paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame tick: fires are sampled mid-cycle while the tick is high.
  task automatic frame();
    frame_tick = 1'b1;
    #2;
    fa1 = a_p1_fire;
    fa2 = a_p2_fire;
    fb1 = b_p1_fire;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    #1;
    chk("fire_width", {15'd0, a_p1_fire | b_p1_fire}, 16'd0);
    step(2);
  endtask

  task automatic tap_space();
    keycode = 16'h002C;
    step(3);
    keycode = 16'h0000;
    step(2);
  endtask

  initial begin
    rst_n      = 1'b0;
    keycode    = 16'h0000;
    frame_tick = 1'b0;
    step(3);
    chk("reset_a", {7'd0, a_p1_dir, a_p1_move, a_p1_fire, a_p2_dir, a_p2_move, a_p2_fire, a_paused}, 16'd0);
    chk("reset_b", {7'd0, b_p1_dir, b_p1_move, b_p1_fire, b_p2_dir, b_p2_move, b_p2_fire, b_paused}, 16'd0);
    rst_n = 1'b1;
    step(2);

    // W press: two-clock latency, then release keeps UP
    keycode = 16'h001A;
    step(1);
    chk("w_latency_move", {15'd0, a_p1_move}, 16'd0);
    step(1);
    chk("w_move", {15'd0, a_p1_move}, 16'd1);
    chk("w_dir", {14'd0, a_p1_dir}, 16'd0);
    keycode = 16'h0000;
    step(2);
    chk("w_rel_move", {15'd0, a_p1_move}, 16'd0);
    chk("w_rel_dir", {14'd0, a_p1_dir}, 16'd0);

    // A, then A+D, then D moves to slot1 alone
    keycode = 16'h0004;
    step(2);
    chk("a_dir_left", {14'd0, a_p1_dir}, 16'd3);
    keycode = 16'h0704;
    step(2);
    chk("ad_dir_right", {14'd0, a_p1_dir}, 16'd1);
    keycode = 16'h0700;
    step(2);
    chk("d_slot1_dir", {14'd0, a_p1_dir}, 16'd1);
    chk("d_slot1_move", {15'd0, a_p1_move}, 16'd1);
    keycode = 16'h0000;
    step(2);
    chk("none_move", {15'd0, a_p1_move}, 16'd0);
    chk("none_dir", {14'd0, a_p1_dir}, 16'd1);

    // Simultaneous S and D edges: right beats down; then P2 Left
    keycode = 16'h1607;
    step(2);
    chk("sd_prio", {14'd0, a_p1_dir}, 16'd1);
    keycode = 16'h0050;
    step(2);
    chk("p2_left", {14'd0, a_p2_dir}, 16'd3);
    chk("p2_left_move", {15'd0, a_p2_move}, 16'd1);
    keycode = 16'h0000;
    step(2);

    // Held Space across 10 ticks: repeat every 3rd on A, single shot on B
    keycode = 16'h002C;
    step(3);
    for (int i = 0; i < 10; i++) begin
      frame();
      chk("rep_fire_a", {15'd0, fa1}, {15'd0, (i % 3) == 0});
      chk("rep_fire_b", {15'd0, fb1}, {15'd0, i == 0});
    end
    keycode = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("drain_fire_a", {15'd0, fa1}, 16'd0);
    end

    // One-shot taps on B: second tap during cooldown is ignored
    tap_space();
    frame();
    chk("tap1_fire", {15'd0, fb1}, 16'd1);
    tap_space();
    frame();
    chk("tap2_ignored", {15'd0, fb1}, 16'd0);
    frame();
    chk("tap2_cd", {15'd0, fb1}, 16'd0);
    frame();
    chk("tap2_cd_end", {15'd0, fb1}, 16'd0);
    tap_space();
    frame();
    chk("tap3_fire", {15'd0, fb1}, 16'd1);

    // Pause: dir tracks, move and fire suppressed, no replay after un-pause
    keycode = 16'h0013;
    step(2);
    chk("pause_on", {15'd0, a_paused}, 16'd1);
    keycode = 16'h0000;
    step(2);
    chk("pause_hold", {15'd0, a_paused}, 16'd1);
    keycode = 16'h0016;
    step(2);
    chk("pause_dir", {14'd0, a_p1_dir}, 16'd2);
    chk("pause_move", {15'd0, a_p1_move}, 16'd0);
    keycode = 16'h2C28;
    step(2);
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("pause_fire", {14'd0, fa1, fa2}, 16'd0);
    end
    keycode = 16'h2C00;
    step(2);
    keycode = 16'h2C29;
    step(2);
    chk("pause_off", {15'd0, a_paused}, 16'd1 - 16'd1);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("no_replay", {14'd0, fa1, fa2}, 16'd0);
    end
    keycode = 16'h0000;
    step(2);

    // Reset mid-cooldown with P2 Up held
    keycode = 16'h522C;
    step(3);
    frame();
    chk("pre_reset_fire", {15'd0, fa1}, 16'd1);
    chk("pre_reset_p2move", {15'd0, a_p2_move}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_dir", {14'd0, a_p1_dir}, 16'd0);
    chk("async_reset_move", {15'd0, a_p2_move}, 16'd0);
    frame_tick = 1'b1;
    #1;
    chk("reset_no_fire", {15'd0, a_p1_fire}, 16'd0);
    frame_tick = 1'b0;
    keycode = 16'h5200;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("post_reset_move", {15'd0, a_p2_move}, 16'd1);
    chk("post_reset_dir", {14'd0, a_p2_dir}, 16'd0);
    chk("post_reset_p1dir", {14'd0, a_p1_dir}, 16'd0);
    for (int i = 0; i < 2; i++) begin
      frame();
      chk("post_reset_fire", {14'd0, fa1, fa2}, 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
